// File: rtl/seq_mult8_ctrl_if.sv
// Handshake and product-register bus for the sequential shift-add multiplier core.
interface seq_mult8_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   dataa;
  logic [WIDTH-1:0]   datab;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod_data;
  logic               prod_clk_en;
  logic               prod_sclr;

  // Requester side: issues operands, observes status and product-register controls
  modport master (
    output start, dataa, datab,
    input  busy, done, prod_data, prod_clk_en, prod_sclr
  );

  // Multiplier core side
  modport slave (
    input  start, dataa, datab,
    output busy, done, prod_data, prod_clk_en, prod_sclr
  );
endinterface

// File: rtl/seq_mult8_ctrl.sv
// Shift-add multiplier core: four half-width partial products, one per cycle,
// summed into a double-width accumulator; drives the downstream product
// register (clear at run start, load at run end).
// WIDTH must be even.
module seq_mult8_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_a,
  seq_mult8_ctrl_if.slave  bus
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    S0,
    S1,
    S2,
    S3,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;

  logic [H-1:0]     a_lo, a_hi, b_lo, b_hi;
  logic [PW-1:0]    pp_ll, pp_hl, pp_lh, pp_hh;

  // Nibble split and zero-extended partial products
  always_comb begin
    a_lo  = a_q[H-1:0];
    a_hi  = a_q[WIDTH-1:H];
    b_lo  = b_q[H-1:0];
    b_hi  = b_q[WIDTH-1:H];
    pp_ll = PW'(a_lo) * PW'(b_lo);
    pp_hl = PW'(a_hi) * PW'(b_lo);
    pp_lh = PW'(a_lo) * PW'(b_hi);
    pp_hh = PW'(a_hi) * PW'(b_hi);
  end

  // State, operand and accumulator registers
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state sequencing and accumulation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.dataa;
          b_d     = bus.datab;
          acc_d   = '0;
          state_d = S0;
        end
      end
      S0: begin
        acc_d   = acc_q + pp_ll;
        state_d = S1;
      end
      S1: begin
        acc_d   = acc_q + (pp_hl << H);
        state_d = S2;
      end
      S2: begin
        acc_d   = acc_q + (pp_lh << H);
        state_d = S3;
      end
      S3: begin
        acc_d   = acc_q + (pp_hh << WIDTH);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode; prod_data is the registered accumulator itself
  always_comb begin
    bus.busy        = (state_q != IDLE);
    bus.done        = (state_q == DONE);
    bus.prod_clk_en = (state_q == S0) || (state_q == DONE);
    bus.prod_sclr   = (state_q != S0);
    bus.prod_data   = acc_q;
  end

endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// Self-checking bench for seq_mult8_ctrl with a behavioural product register.
module tb_seq_mult8_ctrl;

  logic clk = 1'b0;
  logic reset_a = 1'b0;

  seq_mult8_ctrl_if #(.WIDTH(8)) bus ();

  seq_mult8_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Downstream product register: clk_en gated, active-low synchronous clear, no reset
  logic [15:0] preg = 16'h0;
  logic        preload = 1'b0;
  logic [15:0] preload_val = 16'h0;
  always @(posedge clk) begin
    if (preload) preg <= preload_val;
    else if (bus.prod_clk_en) preg <= bus.prod_sclr ? bus.prod_data : 16'h0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One multiply with full timing checks; mid=1 disturbs start/operands in S1
  task automatic run_check(input logic [7:0] a, input logic [7:0] b, input bit mid,
                           input logic [7:0] ga, input logic [7:0] gb,
                           input bit chk_pre, input string tag);
    logic [15:0] exp;
    logic [15:0] res;
    int lat;
    exp = 16'(a) * 16'(b);
    res = 16'h0;
    lat = 0;
    @(negedge clk);
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        chk({tag, "_s0_clk_en"}, 32'(bus.prod_clk_en), 32'd1);
        chk({tag, "_s0_sclr"},   32'(bus.prod_sclr),   32'd0);
        chk({tag, "_s0_busy"},   32'(bus.busy),        32'd1);
        if (chk_pre) chk({tag, "_preload_held"}, 32'(preg), 32'h1234);
      end
      if (k == 2) chk({tag, "_preg_cleared"}, 32'(preg), 32'd0);
      if (bus.done) begin
        lat = k;
        res = bus.prod_data;
        chk({tag, "_done_clk_en"}, 32'(bus.prod_clk_en), 32'd1);
        chk({tag, "_done_sclr"},   32'(bus.prod_sclr),   32'd1);
        break;
      end
      if (mid && k == 2) begin
        bus.start = 1'b1;
        bus.dataa = ga;
        bus.datab = gb;
      end
      if (mid && k == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_prod"}, 32'(res), 32'(exp));
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_preg"}, 32'(preg), 32'(exp));
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vt[6];

  initial begin
    bus.start = 1'b0;
    bus.dataa = 8'h0;
    bus.datab = 8'h0;

    vt[0] = '{8'h12, 8'h34, 16'h03A8};
    vt[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vt[2] = '{8'h80, 8'h02, 16'h0100};
    vt[3] = '{8'h00, 8'hAB, 16'h0000};
    vt[4] = '{8'h03, 8'h05, 16'h000F};
    vt[5] = '{8'h0F, 8'hF0, 16'h0E10};

    // Reset state
    #2;
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_done",    32'(bus.done),        32'd0);
    chk("rst_clk_en",  32'(bus.prod_clk_en), 32'd0);
    chk("rst_sclr",    32'(bus.prod_sclr),   32'd1);
    chk("rst_data",    32'(bus.prod_data),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_a = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_table", i), 32'(16'(vt[i].a) * 16'(vt[i].b)), 32'(vt[i].p));
      run_check(vt[i].a, vt[i].b, 1'b0, 8'h0, 8'h0, 1'b0, $sformatf("vec%0d", i));
    end

    // start and operands disturbed in S1
    run_check(8'h12, 8'h34, 1'b1, 8'hFF, 8'hFF, 1'b0, "midrun");

    // Preloaded product register is cleared by S0 and loaded at DONE
    @(negedge clk);
    preload_val = 16'h1234;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    run_check(8'h03, 8'h05, 1'b0, 8'h0, 8'h0, 1'b1, "preload");

    // Reset asserted in S2 aborts without touching the product register
    begin
      logic [15:0] old;
      @(negedge clk);
      bus.dataa = 8'h12;
      bus.datab = 8'h34;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      old = preg;
      reset_a = 1'b0;
      #1;
      chk("abort_busy",   32'(bus.busy),        32'd0);
      chk("abort_done",   32'(bus.done),        32'd0);
      chk("abort_clk_en", 32'(bus.prod_clk_en), 32'd0);
      chk("abort_sclr",   32'(bus.prod_sclr),   32'd1);
      chk("abort_data",   32'(bus.prod_data),   32'd0);
      @(negedge clk);
      chk("abort_preg_hold1", 32'(preg), 32'(old));
      @(negedge clk);
      chk("abort_preg_hold2", 32'(preg), 32'(old));
      reset_a = 1'b1;
    end
    run_check(8'h0A, 8'h0B, 1'b0, 8'h0, 8'h0, 1'b0, "after_abort");

    // Random operands, some runs disturbed mid-flight
    for (int i = 0; i < 40; i++) begin
      run_check(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom), 1'b0, $sformatf("rnd%0d", i));
    end

    // start held high: back-to-back runs every 6 cycles
    begin
      int prev;
      int pulses;
      prev = -1;
      pulses = 0;
      @(negedge clk);
      bus.dataa = 8'h02;
      bus.datab = 8'h03;
      bus.start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (bus.done) begin
          chk($sformatf("held_prod_c%0d", c), 32'(bus.prod_data), 32'h0006);
          if (prev < 0) chk("held_first", 32'(c), 32'd5);
          else chk($sformatf("held_gap_c%0d", c), 32'(c - prev), 32'd6);
          prev = c;
          pulses++;
        end
      end
      chk("held_pulses", 32'(pulses), 32'd6);
      bus.start = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
